// File: rtl/hub75_pkg.sv
// hub75_pkg -- shared types and default timing for the HUB75 scan controller.
//   state_t      : scan FSM states
//   DEF_*        : default panel geometry and timing
//   LATCH_CYCLES : width of the LAT pulse in clk cycles
//   width_of()   : counter width able to hold 0..n-1 (minimum 1 bit)
package hub75_pkg;

  localparam int unsigned DEF_COLS      = 32;
  localparam int unsigned DEF_ROWS      = 16;
  localparam int unsigned DEF_CLK_DIV   = 2;
  localparam int unsigned DEF_ON_CYCLES = 256;
  localparam int unsigned LATCH_CYCLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_SHOW
  } state_t;

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_timer.sv
// hub75_timer -- loadable down-counter with a zero flag.
// Loading N-1 on the cycle before a state is entered makes done rise on the
// N-th cycle spent in that state.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_value this cycle (takes priority over counting)
//   load_value : start value of the countdown
//   done       : count has reached zero
module hub75_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl -- HUB75 LED panel scan controller.
// Per row: shift COLS pixel pairs (OCLK), blank, latch (LAT), then show
// (OEN low) for ON_CYCLES. Frames repeat while enable is high; enable is
// only looked at in IDLE and at the end of the last row.
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : 1 = scan frames continuously
//   rd_addr / rd_data : {row, col} framebuffer read, data one cycle later
//   r1..b2            : registered colour bits for the upper/lower half
//   A, B, C, D        : row select, A = LSB
//   OCLK, LAT, OEN    : panel shift clock, latch, output enable (active low)
//   frame_done        : one-cycle pulse after the last row of a frame
//
// Panel outputs are registered decodes of the current state, so they show
// up one cycle after the state that produces them. rd_addr is instead
// registered from the next-state counters so it is aligned with the phase
// and the RAM data is ready for the capture at phase step 1.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned ON_CYCLES = DEF_ON_CYCLES
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       enable,
  output logic [width_of(ROWS)+width_of(COLS)-1:0]   rd_addr,
  input  logic [5:0]                                 rd_data,
  output logic                                       r1,
  output logic                                       g1,
  output logic                                       b1,
  output logic                                       r2,
  output logic                                       g2,
  output logic                                       b2,
  output logic                                       A,
  output logic                                       B,
  output logic                                       C,
  output logic                                       D,
  output logic                                       OCLK,
  output logic                                       LAT,
  output logic                                       OEN,
  output logic                                       frame_done
);

  localparam int unsigned ROW_W = width_of(ROWS);
  localparam int unsigned COL_W = width_of(COLS);
  localparam int unsigned K_W   = width_of(2 * CLK_DIV);
  localparam int unsigned TMR_W = width_of((ON_CYCLES > LATCH_CYCLES) ? ON_CYCLES : LATCH_CYCLES);

  localparam logic [K_W-1:0]   K_LAST     = K_W'(2 * CLK_DIV - 1);
  localparam logic [K_W-1:0]   K_CAPTURE  = K_W'(1);
  localparam logic [K_W-1:0]   K_OCLK     = K_W'(CLK_DIV);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [TMR_W-1:0] TMR_LATCH  = TMR_W'(LATCH_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_SHOW   = TMR_W'(ON_CYCLES - 1);

  state_t           state, state_nxt;
  logic [K_W-1:0]   k, k_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [ROW_W-1:0] row, row_nxt;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_done;

  logic             oclk_d, lat_d, oen_d, frame_done_d;
  logic [3:0]       abcd, abcd_d;
  logic [5:0]       rgb;

  // One timer serves both the LATCH and SHOW durations.
  hub75_timer #(
    .WIDTH(TMR_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_value(tmr_value),
    .done      (tmr_done)
  );

  // ---------------------------------------------------------------- FSM ---
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_SHIFT;
      ST_SHIFT: if (k == K_LAST && col == COL_LAST) state_nxt = ST_BLANK;
      ST_BLANK: state_nxt = ST_LATCH;
      ST_LATCH: if (tmr_done) state_nxt = ST_SHOW;
      ST_SHOW: begin
        // A frame in progress always completes; enable only matters here.
        if (tmr_done) state_nxt = (row != ROW_LAST || enable) ? ST_SHIFT : ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    oclk_d       = (state == ST_SHIFT) && (k >= K_OCLK);
    lat_d        = (state == ST_LATCH);
    oen_d        = (state != ST_SHOW);
    frame_done_d = (state == ST_SHOW) && tmr_done && (row == ROW_LAST);
    abcd_d       = (state == ST_BLANK) ? 4'(row) : abcd;
    // Load on the cycle before LATCH/SHOW so done marks their last cycle.
    tmr_load     = (state == ST_BLANK) || ((state == ST_LATCH) && tmr_done);
    tmr_value    = (state == ST_BLANK) ? TMR_LATCH : TMR_SHOW;
  end

  // ----------------------------------------------------------- counters ---
  always_comb begin
    k_nxt   = k;
    col_nxt = col;
    row_nxt = row;
    case (state)
      ST_IDLE: begin
        k_nxt   = '0;
        col_nxt = '0;
        row_nxt = '0;
      end
      ST_SHIFT: begin
        if (k == K_LAST) begin
          k_nxt   = '0;
          col_nxt = (col == COL_LAST) ? '0 : col + 1'b1;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      ST_SHOW: begin
        if (tmr_done) row_nxt = (row == ROW_LAST) ? '0 : row + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k       <= '0;
      col     <= '0;
      row     <= '0;
      rd_addr <= '0;
    end else begin
      k       <= k_nxt;
      col     <= col_nxt;
      row     <= row_nxt;
      rd_addr <= {row_nxt, col_nxt};
    end
  end

  // ------------------------------------------------------ panel outputs ---
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb        <= '0;
      abcd       <= '0;
      OCLK       <= 1'b0;
      LAT        <= 1'b0;
      OEN        <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      // rd_addr has been stable since phase step 0, so the RAM word is valid.
      if (state == ST_SHIFT && k == K_CAPTURE) rgb <= rd_data;
      abcd       <= abcd_d;
      OCLK       <= oclk_d;
      LAT        <= lat_d;
      OEN        <= oen_d;
      frame_done <= frame_done_d;
    end
  end

  assign {r1, g1, b1, r2, g2, b2} = rgb;
  assign {D, C, B, A}             = abcd;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl -- scoreboard bench for hub75_scan_ctrl at default size.
// The stimulus process pushes the expected OCLK rises, LAT pulses and
// frame_done pulses (with their cycle numbers) into queues; a monitor on the
// falling edge pops and compares whenever the DUT shows one of those events.
module tb_hub75_scan_ctrl;

  localparam int COLS      = 32;
  localparam int ROWS      = 16;
  localparam int CLK_DIV   = 2;
  localparam int ON_CYCLES = 256;
  localparam int SHIFT_CYC = COLS * 2 * CLK_DIV;            // 128
  localparam int ROW_CYC   = SHIFT_CYC + 1 + 2 + ON_CYCLES;  // 387
  localparam int FRAME_CYC = ROWS * ROW_CYC;                 // 6192

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [8:0] rd_addr;
  logic [5:0] rd_data = '0;
  logic       r1, g1, b1, r2, g2, b2;
  logic       A, B, C, D;
  logic       OCLK, LAT, OEN, frame_done;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [8:0] addr;
    logic [5:0] rgb;
  } oclk_exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] row;
  } lat_exp_t;

  oclk_exp_t oclk_q[$];
  lat_exp_t  lat_q[$];
  int        fd_q[$];

  hub75_scan_ctrl #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .CLK_DIV  (CLK_DIV),
    .ON_CYCLES(ON_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .r1        (r1),
    .g1        (g1),
    .b1        (b1),
    .r2        (r2),
    .g2        (g2),
    .b2        (b2),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .OCLK      (OCLK),
    .LAT       (LAT),
    .OEN       (OEN),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Cycle counter and synchronous framebuffer model: data = address bits.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= rd_addr[5:0];
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic missing(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Expected events for one row whose frame starts at cycle 'entry'.
  task automatic push_row(input int entry, input int r);
    oclk_exp_t o;
    lat_exp_t  l;
    for (int c = 0; c < COLS; c++) begin
      o.cyc  = entry + r * ROW_CYC + c * 2 * CLK_DIV + CLK_DIV + 1;
      o.addr = 9'(r * COLS + c);
      o.rgb  = 6'(r * COLS + c);
      oclk_q.push_back(o);
    end
    l.cyc = entry + r * ROW_CYC + SHIFT_CYC + 2;
    l.row = 4'(r);
    lat_q.push_back(l);
  endtask

  task automatic push_frame(input int entry);
    for (int r = 0; r < ROWS; r++) push_row(entry, r);
    fd_q.push_back(entry + FRAME_CYC);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_oen"}, OEN, 1);
    check({tag, "_oclk"}, OCLK, 0);
    check({tag, "_lat"}, LAT, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_oclk_q_left"}, oclk_q.size(), 0);
    check({tag, "_lat_q_left"}, lat_q.size(), 0);
    check({tag, "_fd_q_left"}, fd_q.size(), 0);
  endtask

  // ------------------------------------------------------------ monitor ---
  initial begin
    logic       oclk_p = 1'b0, lat_p = 1'b0, oen_p = 1'b1, fd_p = 1'b0;
    int         lat_rise = 0, lat_len = 0, oen_len = 0;
    logic [5:0] rgb_hold = '0;
    oclk_exp_t  o;
    lat_exp_t   l;
    forever begin
      @(negedge clk);
      if (reset) begin
        oclk_p = 1'b0; lat_p = 1'b0; oen_p = 1'b1; fd_p = 1'b0;
        lat_len = 0; oen_len = 0;
      end else begin
        check("panel_invariant", {OCLK && LAT, (OCLK || LAT) && !OEN}, 0);

        if (OCLK && !oclk_p) begin
          if (oclk_q.size() == 0) missing("oclk_rise");
          else begin
            o = oclk_q.pop_front();
            check("oclk_cycle", cyc, o.cyc);
            check("oclk_addr_rgb", {rd_addr, r1, g1, b1, r2, g2, b2}, {o.addr, o.rgb});
          end
        end

        if (LAT && !lat_p) begin
          lat_rise = cyc;
          lat_len  = 1;
          if (lat_q.size() == 0) missing("lat_rise");
          else begin
            l = lat_q.pop_front();
            check("lat_cycle", cyc, l.cyc);
            check("lat_row_dcba", {D, C, B, A}, l.row);
          end
        end else if (LAT) begin
          lat_len++;
        end else if (lat_p) begin
          check("lat_width", lat_len, 2);
        end

        if (!OEN && oen_p) begin
          check("oen_fall_cycle", cyc, lat_rise + 2);
          oen_len  = 1;
          rgb_hold = {r1, g1, b1, r2, g2, b2};
        end else if (!OEN) begin
          oen_len++;
        end else if (!oen_p) begin
          check("show_length", oen_len, ON_CYCLES);
          check("show_rgb_hold", {r1, g1, b1, r2, g2, b2}, rgb_hold);
        end

        if (frame_done) begin
          if (fd_p) missing("frame_done_width");
          else if (fd_q.size() == 0) missing("frame_done");
          else check("frame_done_cycle", cyc, fd_q.pop_front());
        end

        oclk_p = OCLK; lat_p = LAT; oen_p = OEN; fd_p = frame_done;
      end
    end
  end

  // ----------------------------------------------------------- stimulus ---
  initial begin
    int entry;
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_oen", OEN, 1);
    check("reset_oclk_lat", {OCLK, LAT}, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_rgb", {r1, g1, b1, r2, g2, b2}, 0);
    check("reset_dcba_fd", {D, C, B, A, frame_done}, 0);

    // Two back-to-back frames; enable drops during row 7 of the second.
    entry = cyc + 1;
    push_frame(entry);
    push_frame(entry + FRAME_CYC);
    reset = 1'b0;
    wait (cyc >= entry);
    @(negedge clk);
    check("entry_rd_addr", rd_addr, 0);
    check("entry_oen", OEN, 1);

    wait (cyc >= entry + FRAME_CYC + 7 * ROW_CYC + 10);
    @(negedge clk);
    #1 enable = 1'b0;
    wait (cyc >= entry + 2 * FRAME_CYC + 20);
    @(negedge clk);
    #1 check_idle("after_enable_drop");

    // Restart, then reset in the middle of row 3's display time.
    enable = 1'b1;
    entry  = cyc + 1;
    for (int r = 0; r <= 3; r++) push_row(entry, r);
    wait (cyc >= entry + 3 * ROW_CYC + SHIFT_CYC + 3 + 60);
    @(negedge clk);
    #2;
    check("pre_reset_dcba", {D, C, B, A}, 3);
    check("pre_reset_oen", OEN, 0);
    reset = 1'b1;
    #1;
    check("async_reset_oen", OEN, 1);
    check("async_reset_lat_oclk", {LAT, OCLK}, 0);
    check("async_reset_dcba", {D, C, B, A}, 0);
    check("async_reset_rgb_addr", {rgb_bits(), rd_addr}, 0);
    check("reset_oclk_q_left", oclk_q.size(), 0);
    check("reset_lat_q_left", lat_q.size(), 0);
    oclk_q.delete();
    lat_q.delete();
    fd_q.delete();

    // Release with enable held: scanning restarts at row 0 and runs a frame.
    repeat (3) @(negedge clk);
    #1;
    entry = cyc + 1;
    push_frame(entry);
    reset = 1'b0;
    wait (cyc >= entry + ROW_CYC);
    @(negedge clk);
    #1 enable = 1'b0;
    wait (cyc >= entry + FRAME_CYC + 20);
    @(negedge clk);
    #1 check_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [5:0] rgb_bits();
    return {r1, g1, b1, r2, g2, b2};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 Parameter COLS, default 32: columns shifted per row.
REQ-002 Parameter ROWS, default 16: row pairs per frame; the row address is $clog2(ROWS) bits, 4 at the default.
REQ-003 Parameter CLK_DIV, default 2: clk cycles per OCLK half-period; SHALL be >= 2.
REQ-004 Parameter ON_CYCLES, default 256: clk cycles OEN is held low per row.
REQ-005 clk  in  1: single system clock; all logic is rising-edge.
REQ-006 reset  in  1: asynchronous, active-high reset.
REQ-007 enable  in  1: level-sensitive; 1 = scan frames continuously.
REQ-008 rd_addr  out  $clog2(ROWS)+$clog2(COLS) (9 at defaults): {row, col} pixel-pair read address to the framebuffer.
REQ-009 rd_data  in  6: {r1,g1,b1,r2,g2,b2}; valid exactly 1 cycle after rd_addr (synchronous RAM).
REQ-010 r1, g1, b1, r2, g2, b2  out  1 each: registered panel colour bits.
REQ-011 A, B, C, D  out  1 each: row-select bits, A = LSB.
REQ-012 OCLK  out  1: panel shift clock.
REQ-013 LAT  out  1: panel latch, active-high.
REQ-014 OEN  out  1: panel output enable, active-low (1 = blanked).
REQ-015 frame_done  out  1: one-cycle pulse at the end of the last row of each frame.

Function
REQ-016 FSM states: IDLE, SHIFT, BLANK, LATCH, SHOW.
- IDLE: OEN=1, OCLK=0, LAT=0.
- IDLE -> SHIFT on the first edge with enable=1; row=0, col=0.
REQ-017 SHIFT: each column is a 2*CLK_DIV-cycle phase, phase counter k = 0..2*CLK_DIV-1.
- rd_addr = {row, col} for the whole phase.
- rgb outputs load rd_data at k=1.
- OCLK=1 for k >= CLK_DIV, else 0.
- col increments after the last k; col=COLS-1 -> col=0 and the FSM goes to BLANK.
REQ-018 BLANK lasts 1 cycle: OEN=1, OCLK=0, {D,C,B,A} updated to row.
REQ-019 LATCH lasts 2 cycles: LAT=1, OEN=1, then -> SHOW.
REQ-020 SHOW lasts ON_CYCLES cycles: OEN=0, LAT=0, OCLK=0; rgb outputs hold their value.
REQ-021 At the end of SHOW, when row != ROWS-1: row increments and the FSM goes to SHIFT.
REQ-022 At the end of SHOW, when row = ROWS-1:
- frame_done=1 for that final cycle;
- row wraps to 0;
- next state is SHIFT if enable=1, else IDLE.
REQ-023 enable is sampled only in IDLE and at the end of the last row (REQ-022).
- Deasserting enable mid-frame SHALL NOT abort the frame; the frame completes.
REQ-024 Row timing at defaults: SHIFT 128 + BLANK 1 + LATCH 2 + SHOW 256 = 387 cycles; frame = 6192 cycles.
REQ-025 OEN SHALL be 1 whenever LAT=1 or OCLK toggles; OCLK and LAT SHALL never be 1 together.
REQ-026 All outputs SHALL be registered (glitch-free at the panel).

Reset
REQ-027 reset=1 SHALL force, asynchronously:
- state = IDLE;
- row, col and k = 0;
- OEN=1, OCLK=0, LAT=0;
- rgb outputs = 0, A-D = 0, rd_addr = 0, frame_done=0.
REQ-028 Reset mid-row SHALL blank the panel immediately and leave no partial latch (LAT=0).
REQ-029 After reset release, scanning restarts at row 0, col 0 on the first edge with enable=1.

Structure
REQ-030 Shared package hub75_pkg SHALL hold the state enum type and the default timing constants (COLS, ROWS, CLK_DIV, ON_CYCLES).
REQ-031 One sub-module, hub75_timer, SHALL be a loadable down-counter with a done flag, shared by the SHOW and LATCH durations.
REQ-032 The row and column counters stay in hub75_scan_ctrl.

Verification
REQ-033 Reset with enable=1 held -> after release, OEN=1 and first OCLK rise at cycle 1+CLK_DIV after the SHIFT entry; rd_addr=0x000.
REQ-034 Framebuffer model returns rd_data=addr[5:0] -> shift capture at OCLK rises shows 32 values per row that match their addresses; LAT high 2 cycles; {D,C,B,A}=row.
REQ-035 Full frame at defaults -> 16 LAT pulses, 512 OCLK rises, frame_done once at cycle 6192 after SHIFT entry; rows 0..15 then wrap to 0.
REQ-036 enable dropped during row 7 -> frame completes through row 15, frame_done pulses, FSM enters IDLE with OEN=1.
REQ-037 reset asserted mid-SHOW of row 3 -> same cycle OEN=1, LAT=0, A-D=0; restart scans row 0.
REQ-038 Assertion, every cycle: not (OCLK && LAT); OEN=1 whenever LAT=1 or during SHIFT.
